// File: rtl/regfile.sv
// regfile: MIPS five-stage pipeline general-purpose register file.
//   Two combinational read ports for decode, with a same-cycle write-to-read
//   bypass. One write port from write-back. $0 always reads zero and is
//   never written.
//   The debug read port shows raw storage and never bypasses.
//   wr_count counts committed (non-$0) writes since reset.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   we/waddr/wdata  write-back request
//   re1/raddr1/rdata1, re2/raddr2/rdata2  decode read ports
//   dbg_addr/dbg_data                     raw storage read
//   wr_count                              committed-write counter
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_count
);
    localparam int NUM_RD = 2;

    // Entry 0 is reset to zero and never written. The read paths also
    // force address 0 to zero, so the entry's contents are never observed.
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [31:0]       wr_count_q, wr_count_d;
    logic              wr_commit;

    logic [NUM_RD-1:0]             re_v;
    logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;

    // Writes to $0 are dropped entirely; they are not counted.
    assign wr_commit  = we && (waddr != '0);
    assign wr_count_d = wr_count_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_count_q <= '0;
        end else if (wr_commit) begin
            regs_q[waddr] <= wdata;
            wr_count_q    <= wr_count_d;
        end
    end

    assign re_v    = {re2, re1};
    assign raddr_v = {raddr2, raddr1};

    // Read priority: reset, $0, bypass, storage, then disabled.
    // The bypass is safe for $0 because the $0 check comes before it.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        always_comb begin
            rdata_v[p] = '0;
            if (!rst && raddr_v[p] != '0 && re_v[p]) begin
                if (we && waddr == raddr_v[p]) rdata_v[p] = wdata;
                else                           rdata_v[p] = regs_q[raddr_v[p]];
            end
        end
    end

    assign rdata1 = rdata_v[0];
    assign rdata2 = rdata_v[1];

    assign dbg_data = (rst || dbg_addr == '0) ? '0 : regs_q[dbg_addr];
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile.sv
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2, dbg_addr;
    logic [31:0] rdata1, rdata2, dbg_data, wr_count;

    int tests = 0;
    int fails = 0;

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Write one register at the next rising edge, then drop we.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd1; raddr2 = 5'd2; dbg_addr = 5'd1;
        #12;
        tests++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0 || dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdata1=%h rdata2=%h dbg=%h expected 0", rdata1, rdata2, dbg_data);
        end
        tests++;
        if (wr_count !== 32'd0) begin
            fails++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
        end
        @(negedge clk); rst = 1'b0;
        for (int a = 1; a < 32; a++) begin
            raddr1 = a[4:0]; raddr2 = a[4:0]; #1;
            tests++;
            if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
                fails++;
                $display("FAIL reset_read_%0d: rdata1=%h rdata2=%h expected 0", a, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_write_read();
        re1 = 1'b0; re2 = 1'b0;
        do_write(5'd5, 32'h1234_5678);
        re1 = 1'b1; raddr1 = 5'd5; dbg_addr = 5'd5; #1;
        tests++;
        if (rdata1 !== 32'h1234_5678) begin
            fails++; $display("FAIL write_read: got %h expected 12345678", rdata1);
        end
        tests++;
        if (dbg_data !== 32'h1234_5678) begin
            fails++; $display("FAIL write_dbg: got %h expected 12345678", dbg_data);
        end
        tests++;
        if (wr_count !== 32'd1) begin
            fails++; $display("FAIL write_count: got %0d expected 1", wr_count);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7; dbg_addr = 5'd7; #1;
        tests++;
        if (rdata1 !== 32'hDEAD_BEEF || rdata2 !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL bypass_ports: rdata1=%h rdata2=%h expected deadbeef", rdata1, rdata2);
        end
        tests++;
        if (dbg_data !== 32'd0) begin
            fails++; $display("FAIL bypass_dbg_old: got %h expected 0", dbg_data);
        end
        @(posedge clk); #1;
        we = 1'b0; #1;
        tests++;
        if (dbg_data !== 32'hDEAD_BEEF || rdata1 !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL bypass_commit: dbg=%h rdata1=%h expected deadbeef", dbg_data, rdata1);
        end
        tests++;
        if (wr_count !== 32'd2) begin
            fails++; $display("FAIL bypass_count: got %0d expected 2", wr_count);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0; dbg_addr = 5'd0; #1;
        tests++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            fails++;
            $display("FAIL zero_no_bypass: rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
        end
        @(posedge clk); #1;
        we = 1'b0; #1;
        tests++;
        if (rdata1 !== 32'd0 || dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL zero_read: rdata1=%h dbg=%h expected 0", rdata1, dbg_data);
        end
        tests++;
        if (wr_count !== 32'd2) begin
            fails++; $display("FAIL zero_count: got %0d expected 2", wr_count);
        end
    endtask

    task automatic test_re_low();
        do_write(5'd3, 32'hA5A5_A5A5);
        re2 = 1'b0; raddr2 = 5'd3; #1;
        tests++;
        if (rdata2 !== 32'd0) begin
            fails++; $display("FAIL re_low: got %h expected 0", rdata2);
        end
        re2 = 1'b1; #1;
        tests++;
        if (rdata2 !== 32'hA5A5_A5A5) begin
            fails++; $display("FAIL re_high: got %h expected a5a5a5a5", rdata2);
        end
        tests++;
        if (wr_count !== 32'd3) begin
            fails++; $display("FAIL re_count: got %0d expected 3", wr_count);
        end
    endtask

    task automatic test_async_reset();
        do_write(5'd9, 32'h0000_00FF);
        dbg_addr = 5'd9; #1;
        tests++;
        if (dbg_data !== 32'h0000_00FF || wr_count !== 32'd4) begin
            fails++;
            $display("FAIL async_pre: dbg=%h count=%0d expected ff/4", dbg_data, wr_count);
        end
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_1234;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd3; #1;
        tests++;
        if (rdata1 !== 32'h0000_1234) begin
            fails++; $display("FAIL async_bypass: got %h expected 1234", rdata1);
        end
        // Reset asserted between edges: outputs and state clear at once.
        rst = 1'b1; #1;
        tests++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0 || dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL async_outputs: rdata1=%h rdata2=%h dbg=%h expected 0", rdata1, rdata2, dbg_data);
        end
        tests++;
        if (wr_count !== 32'd0) begin
            fails++; $display("FAIL async_count: got %0d expected 0", wr_count);
        end
        @(posedge clk); #1;
        we = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        tests++;
        if (rdata1 !== 32'd0 || dbg_data !== 32'd0 || rdata2 !== 32'd0) begin
            fails++;
            $display("FAIL async_after: rdata1=%h rdata2=%h dbg=%h expected 0", rdata1, rdata2, dbg_data);
        end
        tests++;
        if (wr_count !== 32'd0) begin
            fails++; $display("FAIL async_after_count: got %0d expected 0", wr_count);
        end
        do_write(5'd9, 32'h0BAD_F00D);
        #1;
        tests++;
        if (rdata1 !== 32'h0BAD_F00D || wr_count !== 32'd1) begin
            fails++;
            $display("FAIL post_reset_write: rdata1=%h count=%0d expected badf00d/1", rdata1, wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_re_low();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
